// File: rtl/mem_stage.sv
// mem_stage: memory stage behind the execute stage.
// Performs word loads and stores to an internal data memory that has a fixed
// wait latency. It holds the upstream pipeline with freeze while an access is
// in flight.
// Optional feature: define MEM_BOUNDS_CHECK_EN to add the addr_err output.
// Accesses outside the memory window then have their store suppressed, or
// their load forced to zero, instead of wrapping modulo DEPTH.
module mem_stage #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Val_Rm,
    output logic [31:0] mem_result,
    output logic        freeze,
`ifdef MEM_BOUNDS_CHECK_EN
    output logic        addr_err,
`endif
    output logic        ready
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   data_q, data_d;
    logic          wr_q, wr_d;
    logic [31:0]   mem_result_q, mem_result_d;
    logic          ready_q, ready_d;
    logic          mem_we;
    logic          req;
    logic [AW-1:0] idx_in;
    logic [31:0]   mem [DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
    logic          oob_q, oob_d;
    logic          addr_err_q, addr_err_d;
    logic          oob_in;

    // The subtraction wraps for addresses below the base, so one unsigned compare covers both sides of the window.
    assign oob_in = (ALU_result - BASE_ADDR) >= 32'(4 * DEPTH);
    assign addr_err = addr_err_q;
`endif

    assign req        = MEM_R_EN | MEM_W_EN;
    assign idx_in     = AW'((ALU_result - BASE_ADDR) >> 2);
    assign mem_result = mem_result_q;
    assign ready      = ready_q;

    // State and datapath registers; the memory array itself is never reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            wr_q         <= 1'b0;
            mem_result_q <= '0;
            ready_q      <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            oob_q        <= 1'b0;
            addr_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            wr_q         <= wr_d;
            mem_result_q <= mem_result_d;
            ready_q      <= ready_d;
`ifdef MEM_BOUNDS_CHECK_EN
            oob_q        <= oob_d;
            addr_err_q   <= addr_err_d;
`endif
        end
    end

    // Store commit; a reset on the completing edge abandons the pending store.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[idx_q] <= data_q;
        end
    end

    // Next-state: DONE always returns to IDLE so the same instruction is not re-issued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the request at issue, then complete it once the wait counter reaches zero.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        data_d       = data_q;
        wr_d         = wr_q;
        mem_result_d = mem_result_q;
        ready_d      = 1'b0;
        mem_we       = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        oob_d        = oob_q;
        addr_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d  = idx_in;
                    data_d = Val_Rm;
                    wr_d   = MEM_W_EN;
                    cnt_d  = 4'(WAIT_CYCLES);
`ifdef MEM_BOUNDS_CHECK_EN
                    oob_d  = oob_in;
`endif
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
                    addr_err_d = oob_q;
                    if (wr_q) begin
                        mem_we = !oob_q;
                    end else begin
                        mem_result_d = oob_q ? 32'd0 : mem[idx_q];
                    end
`else
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        mem_result_d = mem[idx_q];
                    end
`endif
                end
            end
            default: begin
            end
        endcase
    end

    // Output: stall upstream for a new request in IDLE and for the whole BUSY phase.
    always_comb begin
        freeze = 1'b0;
        case (state_q)
            IDLE:    freeze = req;
            BUSY:    freeze = 1'b1;
            default: freeze = 1'b0;
        endcase
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-stage consumer of the execute stage's outputs.
- Takes ALU_result as the byte address, Val_Rm as store data, and MEM_R_EN/MEM_W_EN as the access request.
- Performs word accesses to an internal data memory that has a fixed, parameterised wait latency.
- Drives freeze to stall the upstream pipeline while an access is in flight, then presents load data on mem_result for writeback.

Parameters:
- DEPTH, 64: number of 32-bit words in data memory; must be a power of two.
- BASE_ADDR, 1024: byte address mapped to word 0.
- WAIT_CYCLES, 2: extra busy cycles per access; valid range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- MEM_R_EN  in  1  load request from execute stage.
- MEM_W_EN  in  1  store request from execute stage.
- ALU_result  in  32  byte address.
- Val_Rm  in  32  store data.
- mem_result  out  32  load data; registered.
- freeze  out  1  stall request to upstream stages; combinational from state and request.
- ready  out  1  one-cycle access-complete pulse; registered.

Behaviour:
- Reset (rst=1 at an edge):
  - state becomes IDLE; wait counter cleared.
  - mem_result=0, ready=0.
  - Memory array is not cleared.
  - An in-flight access is abandoned; a pending store is not committed.
- Word index: (ALU_result - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits, so out-of-window addresses wrap modulo DEPTH.
- Address bits [1:0] are ignored.
- req = MEM_R_EN | MEM_W_EN.
- If both enables are high, the access is a store; mem_result keeps its previous value.
- IDLE:
  - freeze = req.
  - If req at the edge: latch index, Val_Rm and the write flag; load counter with WAIT_CYCLES; go to BUSY.
- BUSY:
  - freeze=1.
  - If counter != 0, decrement.
  - If counter == 0 at the edge:
    - store: mem[index] <= latched data.
    - load: mem_result <= mem[index].
    - ready <= 1; go to DONE.
- DONE:
  - freeze=0; ready=1 for exactly this cycle.
  - Requests are ignored here: the upstream pipeline still shows the same instruction, and it must not re-issue.
  - Next edge: ready <= 0; go to IDLE.
- Latency: a request first seen in IDLE in cycle 0 gives:
  - freeze=1 for cycles 0..WAIT_CYCLES+1;
  - DONE in cycle WAIT_CYCLES+2, with mem_result valid from that cycle.
  - With WAIT_CYCLES=0 the access takes 3 cycles in total.
- mem_result holds its value until the next completed load or a reset.
- Input changes during BUSY have no effect, because address, data and type were latched at issue.
- Back-to-back accesses: the second request is sampled in the IDLE cycle after DONE. There is always at least one idle cycle between accesses.
- Non-memory instructions (req=0) pass with freeze=0 and leave all state unchanged.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- When defined:
  - Extra output addr_err (1 bit, registered, reset 0).
  - An access whose ALU_result lies outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) is out of window. Its store is suppressed, or its load returns 0.
  - addr_err pulses together with ready; timing is unchanged.
- When undefined: no addr_err port; out-of-window addresses wrap modulo DEPTH as above.

Test Plan:
- Reset, then hold req=0 for 5 cycles -> freeze=0, ready=0 and mem_result=0 throughout.
- Store with WAIT_CYCLES=2, ALU_result=1028, Val_Rm=0xDEADBEEF, MEM_W_EN=1 -> freeze=1 for 4 cycles, ready=1 in cycle 4. A later load from 1028 returns 0xDEADBEEF with freeze=1 for 4 cycles, and mem_result=0xDEADBEEF in the ready cycle.
- Store 0x11 to 1024, then load from 1024+4*DEPTH (=1280) -> mem_result=0x11 (wrap). With MEM_BOUNDS_CHECK_EN defined: mem_result=0 and addr_err=1.
- MEM_R_EN=MEM_W_EN=1, ALU_result=1032, Val_Rm=0x55 -> treated as a store: mem_result unchanged, and a later load from 1032 returns 0x55.
- Issue a store of 0x77 to 1036, assert rst in the first BUSY cycle -> state IDLE and ready=0 after the edge. A later load from 1036 returns the pre-store contents (not 0x77).
- Hold MEM_R_EN=1 and ALU_result constant across the DONE cycle -> exactly one access completes per issue. The ready pulse is followed by one IDLE cycle with freeze=1, then a fresh access.
